dot_product_accum: RTL and testbench

- Downstream consumer and operand feeder for the 8x8 pipelined unsigned multiplier (`mult8x8`).
- Drives the multiplier's operand inputs from a valid/last operand stream.
- Carries valid/last through a delay line matched to the multiplier's latency, sums the returning products per frame, and emits one dot-product result per frame.
- The multiplier itself has no reset and no valid; this block supplies both concepts.

---
 rtl/dot_product_accum.sv | 103 ++++++++++
 tb/tb_dot_product_accum.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accum.sv
// Operand feeder and per-frame accumulator for the mult8x8 pipelined multiplier.
// Valid/last ride a delay line matched to the multiplier so each product meets its own tag.
module dot_product_accum #(
  parameter int MULT_LATENCY = 5,
  parameter int ACC_WIDTH    = 24,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [7:0]           in_a,
  input  logic [7:0]           in_b,
  output logic [7:0]           mult_a,
  output logic [7:0]           mult_b,
  input  logic [15:0]          mult_p,
  output logic                 acc_valid,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic [CNT_WIDTH-1:0] term_count,
  output logic                 overflow,
  output logic                 busy
);

  logic [MULT_LATENCY-1:0] dl_v;
  logic [MULT_LATENCY-1:0] dl_l;
  logic                    tap_v;
  logic                    tap_l;

  logic [ACC_WIDTH-1:0]    acc;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    sticky;
  logic                    first;

  logic [ACC_WIDTH-1:0]    acc_base;
  logic [ACC_WIDTH:0]      sum;
  logic [CNT_WIDTH-1:0]    cnt_next;
  logic                    ovf_next;

  // Gating keeps the multiplier inputs quiet when nothing valid is offered.
  assign mult_a = in_valid ? in_a : 8'd0;
  assign mult_b = in_valid ? in_b : 8'd0;

  assign tap_v = dl_v[MULT_LATENCY-1];
  assign tap_l = dl_l[MULT_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_v <= '0;
      dl_l <= '0;
    end else begin
      dl_v[0] <= in_valid;
      dl_l[0] <= in_valid & in_last;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_l[i] <= dl_l[i-1];
      end
    end
  end

  // The first term of a frame replaces stale state instead of adding to it.
  always_comb begin
    acc_base = first ? '0 : acc;
    sum      = {1'b0, acc_base} + {{(ACC_WIDTH-15){1'b0}}, mult_p};
    ovf_next = (first ? 1'b0 : sticky) | sum[ACC_WIDTH];
    if (first) begin
      cnt_next = CNT_WIDTH'(1);
    end else if (cnt == {CNT_WIDTH{1'b1}}) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      sticky     <= 1'b0;
      first      <= 1'b1;
      acc_valid  <= 1'b0;
      acc_out    <= '0;
      term_count <= '0;
      overflow   <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (tap_v) begin
        acc    <= sum[ACC_WIDTH-1:0];
        sticky <= ovf_next;
        cnt    <= cnt_next;
        first  <= tap_l;
        if (tap_l) begin
          acc_out    <= sum[ACC_WIDTH-1:0];
          overflow   <= ovf_next;
          term_count <= cnt_next;
          acc_valid  <= 1'b1;
        end
      end
    end
  end

  assign busy = (|dl_v) | ~first;

endmodule

// File: tb/tb_dot_product_accum.sv
// Randomized and directed bench for dot_product_accum with a behavioural mult8x8 stand-in.
module tb_dot_product_accum;

  localparam int LAT = 5;
  localparam int AW  = 24;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [7:0]    in_a = 8'd0;
  logic [7:0]    in_b = 8'd0;
  logic [7:0]    mult_a;
  logic [7:0]    mult_b;
  logic [15:0]   mult_p;
  logic          acc_valid;
  logic [AW-1:0] acc_out;
  logic [CW-1:0] term_count;
  logic          overflow;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  dot_product_accum #(.MULT_LATENCY(LAT), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_a(in_a), .in_b(in_b), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .acc_valid(acc_valid), .acc_out(acc_out), .term_count(term_count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: no reset, product appears LAT edges after operand capture.
  logic [15:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mult_a * mult_b;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_p = mpipe[LAT-1];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: exact frame sums, results queued with their due cycle.
  typedef struct {
    longint sum;
    longint cnt;
    int     due;
  } result_t;

  result_t exp_q[$];
  longint  frame_sum = 0;
  longint  frame_cnt = 0;
  longint  last_out = 0;
  longint  last_cnt = 0;
  longint  last_ovf = 0;

  function automatic longint lim(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  task automatic model_term(input logic [7:0] a, input logic [7:0] b, input logic l);
    result_t r;
    frame_sum += longint'(a) * longint'(b);
    frame_cnt++;
    if (l) begin
      r.sum = frame_sum;
      r.cnt = frame_cnt;
      r.due = cyc + LAT + 1;
      exp_q.push_back(r);
      frame_sum = 0;
      frame_cnt = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (acc_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pulse", 1, 0);
        end else begin
          result_t r;
          r = exp_q.pop_front();
          last_out = r.sum & lim(AW);
          last_cnt = (r.cnt > lim(CW)) ? lim(CW) : r.cnt;
          last_ovf = (r.sum > lim(AW)) ? 1 : 0;
          chk("pulse_cycle", cyc, r.due);
          chk("acc_out", acc_out, last_out);
          chk("term_count", term_count, last_cnt);
          chk("overflow", overflow, last_ovf);
        end
      end else begin
        chk("hold_acc_out", acc_out, last_out);
        chk("hold_term_count", term_count, last_cnt);
        chk("hold_overflow", overflow, last_ovf);
        if (exp_q.size() != 0 && cyc > exp_q[0].due) chk("missing_pulse", cyc, exp_q[0].due);
      end
    end
  end

  // Called at a negedge; returns at the next negedge after the sampling edge.
  task automatic drive(input logic v, input logic l, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in_last  = l;
    in_a     = a;
    in_b     = b;
    #1;
    chk("mult_a", mult_a, v ? a : 8'd0);
    chk("mult_b", mult_b, v ? b : 8'd0);
    if (v) model_term(a, b, l);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
  endtask

  task automatic drain();
    int k;
    k = 0;
    idle(1);
    while (exp_q.size() != 0 && k < 40) begin
      idle(1);
      k++;
    end
    chk("drain_pending", exp_q.size(), 0);
    idle(2);
    chk("busy_idle", busy, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    exp_q.delete();
    frame_sum = 0;
    frame_cnt = 0;
    last_out = 0;
    last_cnt = 0;
    last_ovf = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_acc_valid", acc_valid, 0);
    chk("reset_acc_out", acc_out, 0);
    chk("reset_term_count", term_count, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single term.
    drive(1, 1, 8'd255, 8'd255);
    drain();
    chk("single_out", acc_out, 65025);

    // Three terms.
    for (int i = 0; i < 3; i++) drive(1, i == 2, 8'd255, 8'd255);
    drain();
    chk("three_out", acc_out, 195075);
    chk("three_cnt", term_count, 3);

    // Back-to-back frames.
    drive(1, 1, 8'd2, 8'd3);
    drive(1, 0, 8'd4, 8'd5);
    drive(1, 1, 8'd1, 8'd1);
    drain();
    chk("b2b_out", acc_out, 21);
    chk("b2b_cnt", term_count, 2);

    // Gap inside a frame.
    drive(1, 0, 8'd10, 8'd10);
    idle(3);
    drive(1, 1, 8'd3, 8'd3);
    drain();
    chk("gap_out", acc_out, 109);

    // Overflow and count saturation, then a clean frame.
    for (int i = 0; i < 259; i++) drive(1, i == 258, 8'd255, 8'd255);
    drain();
    chk("ovf_out", acc_out, 64259);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt", term_count, 255);
    drive(1, 1, 8'd1, 8'd1);
    drain();
    chk("post_ovf_out", acc_out, 1);
    chk("post_ovf_flag", overflow, 0);

    // Reset with terms in flight.
    drive(1, 0, 8'd9, 8'd9);
    drive(1, 0, 8'd9, 8'd9);
    pulse_reset();
    drive(1, 1, 8'd7, 8'd7);
    drain();
    chk("abort_out", acc_out, 49);
    chk("abort_cnt", term_count, 1);

    // Random frames with random gaps.
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        drive(1, t == len - 1, 8'($urandom), 8'($urandom));
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
